alu_ctrl_pipe: RTL

- Parametrised successor to the single-cycle ALU-control decoder for the barrel-processor core.
- Decodes i_ALUctrl/funct3/funct7 into an ALU opcode and covers RV32M when enabled.
- Flags illegal encodings instead of silently emitting a default op.
- Carries valid and hart-ID through a configurable register pipeline, supports per-hart flush, and tracks occupancy of the single shared iterative divider, rejecting (replaying) divide ops that collide with a busy divider.

---
 rtl/alu_ctrl_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_pipe.sv
// ALU-control decoder with RV32M support, illegal-encoding flagging, a valid/hart
// delay pipeline with per-hart flush, and occupancy tracking for the shared divider.
module alu_ctrl_pipe #(
  parameter int STAGES      = 1,
  parameter int NUM_HARTS   = 16,
  parameter int ENABLE_M    = 1,
  parameter int DIV_CYCLES  = 34,
  parameter int ALUOP_WIDTH = 5,
  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [HW-1:0]          i_hart_id,
  input  logic [3:0]             i_ALUctrl,
  input  logic [2:0]             i_funct3,
  input  logic [6:0]             i_funct7,
  input  logic                   i_flush,
  input  logic [HW-1:0]          i_flush_hart,
  output logic                   o_valid,
  output logic [HW-1:0]          o_hart_id,
  output logic [ALUOP_WIDTH-1:0] o_ALUOp,
  output logic                   o_illegal,
  output logic                   o_replay,
  output logic [HW-1:0]          o_replay_hart,
  output logic                   o_div_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  typedef logic [ALUOP_WIDTH-1:0] op_t;

  localparam op_t OP_ADD  = op_t'(0);
  localparam op_t OP_SUB  = op_t'(1);
  localparam op_t OP_SLL  = op_t'(2);
  localparam op_t OP_SLT  = op_t'(3);
  localparam op_t OP_SLTU = op_t'(4);
  localparam op_t OP_XOR  = op_t'(5);
  localparam op_t OP_SRL  = op_t'(6);
  localparam op_t OP_SRA  = op_t'(7);
  localparam op_t OP_OR   = op_t'(8);
  localparam op_t OP_AND  = op_t'(9);
  localparam op_t OP_PASS = op_t'(10);
  localparam op_t OP_MUL  = op_t'(11);
  localparam op_t OP_DIV  = op_t'(15);

  op_t           dec_op_d;
  logic          dec_ill_d;
  logic          is_div_d;
  logic          div_accept_d;
  logic          div_reject_d;
  logic [CW-1:0] div_cnt_d;

  logic          vld_q  [STAGES];
  logic [HW-1:0] hart_q [STAGES];
  op_t           op_q   [STAGES];
  logic          ill_q  [STAGES];
  logic [CW-1:0] div_cnt_q;
  logic          div_busy_q;
  logic          replay_q;
  logic [HW-1:0] replay_hart_q;

  // Opcode decode; an illegal encoding leaves the opcode at ADD
  always_comb begin
    dec_op_d  = OP_ADD;
    dec_ill_d = 1'b0;
    case (i_ALUctrl)
      4'b0000: dec_op_d = OP_ADD;
      4'b0001: dec_op_d = OP_SUB;
      4'b0011: dec_op_d = OP_PASS;
      4'b0010: begin
        case (i_funct7)
          7'b0000000: begin
            case (i_funct3)
              3'b000:  dec_op_d = OP_ADD;
              3'b001:  dec_op_d = OP_SLL;
              3'b010:  dec_op_d = OP_SLT;
              3'b011:  dec_op_d = OP_SLTU;
              3'b100:  dec_op_d = OP_XOR;
              3'b101:  dec_op_d = OP_SRL;
              3'b110:  dec_op_d = OP_OR;
              3'b111:  dec_op_d = OP_AND;
              default: dec_ill_d = 1'b1;
            endcase
          end
          7'b0100000: begin
            if (i_funct3 == 3'b000) begin
              dec_op_d = OP_SUB;
            end else if (i_funct3 == 3'b101) begin
              dec_op_d = OP_SRA;
            end else begin
              dec_ill_d = 1'b1;
            end
          end
          7'b0000001: begin
            // RV32M ops are laid out contiguously from MUL in funct3 order
            if (ENABLE_M != 0) begin
              dec_op_d = OP_MUL + op_t'(i_funct3);
            end else begin
              dec_ill_d = 1'b1;
            end
          end
          default: dec_ill_d = 1'b1;
        endcase
      end
      4'b0100: begin
        case (i_funct3)
          3'b000:  dec_op_d = OP_ADD;
          3'b010:  dec_op_d = OP_SLT;
          3'b011:  dec_op_d = OP_SLTU;
          3'b100:  dec_op_d = OP_XOR;
          3'b110:  dec_op_d = OP_OR;
          3'b111:  dec_op_d = OP_AND;
          3'b001: begin
            if (i_funct7 == 7'b0000000) begin
              dec_op_d = OP_SLL;
            end else begin
              dec_ill_d = 1'b1;
            end
          end
          3'b101: begin
            if (i_funct7 == 7'b0000000) begin
              dec_op_d = OP_SRL;
            end else if (i_funct7 == 7'b0100000) begin
              dec_op_d = OP_SRA;
            end else begin
              dec_ill_d = 1'b1;
            end
          end
          default: dec_ill_d = 1'b1;
        endcase
      end
      default: dec_ill_d = 1'b1;
    endcase
  end

  // Shared-divider arbitration and busy-counter next state
  always_comb begin
    is_div_d     = !dec_ill_d && (dec_op_d >= OP_DIV);
    div_accept_d = i_valid && is_div_d && !div_busy_q;
    div_reject_d = i_valid && is_div_d && div_busy_q;
    if (div_accept_d) begin
      div_cnt_d = CW'(DIV_CYCLES);
    end else if (div_cnt_q != {CW{1'b0}}) begin
      div_cnt_d = div_cnt_q - CW'(1);
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Pipeline stages, divider counter and replay pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        hart_q[k] <= '0;
        op_q[k]   <= OP_ADD;
        ill_q[k]  <= 1'b0;
      end
      div_cnt_q     <= '0;
      div_busy_q    <= 1'b0;
      replay_q      <= 1'b0;
      replay_hart_q <= '0;
    end else begin
      vld_q[0]  <= i_valid && !div_reject_d && !(i_flush && (i_hart_id == i_flush_hart));
      hart_q[0] <= i_hart_id;
      op_q[0]   <= dec_op_d;
      ill_q[0]  <= dec_ill_d;
      // An entry is killed while moving between stages if its hart is flushed
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k]  <= vld_q[k-1] && !(i_flush && (hart_q[k-1] == i_flush_hart));
        hart_q[k] <= hart_q[k-1];
        op_q[k]   <= op_q[k-1];
        ill_q[k]  <= ill_q[k-1];
      end
      div_cnt_q  <= div_cnt_d;
      div_busy_q <= (div_cnt_d != {CW{1'b0}});
      replay_q   <= div_reject_d;
      if (div_reject_d) begin
        replay_hart_q <= i_hart_id;
      end else begin
        replay_hart_q <= replay_hart_q;
      end
    end
  end

  assign o_valid       = vld_q[STAGES-1];
  assign o_hart_id     = hart_q[STAGES-1];
  assign o_ALUOp       = op_q[STAGES-1];
  assign o_illegal     = ill_q[STAGES-1];
  assign o_replay      = replay_q;
  assign o_replay_hart = replay_hart_q;
  assign o_div_busy    = div_busy_q;

endmodule
